instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32 core: owns the PC, fetches over a req/ack handshake
// and holds each instruction stable until the downstream stage releases it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_retired;
  logic        r_valid;
  logic        r_fault;

  logic        w_capture;
  logic        w_release;
  logic        w_misalign;
  logic        w_redirect;
  logic        w_seq;

  // ack only matters while a request is outstanding; stall/branch only in HOLD
  assign w_capture  = (r_state == S_REQ) && imem_ack;
  assign w_release  = (r_state == S_HOLD) && !stall;
  assign w_misalign = branch_target[1:0] != 2'b00;
  assign w_redirect = w_release && branch_taken && !w_misalign;
  assign w_seq      = w_release && !branch_taken;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ:   if (imem_ack) w_next = S_HOLD;
      S_HOLD: begin
        if (!stall) begin
          if (branch_taken && w_misalign) w_next = S_FAULT;
          else                            w_next = S_REQ;
        end
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  // The dead cycle after reset comes from starting in S_IDLE, so a stale ack
  // arriving right after reset release can never be captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_pc_out  <= RESET_PC;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      if (w_capture) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
      end
      if (w_release) begin
        r_valid   <= 1'b0;
        r_retired <= r_retired + 32'd1;
      end
      if (w_seq)                               r_pc    <= r_pc + 32'd4;
      if (w_redirect)                          r_pc    <= branch_target;
      if (w_release && branch_taken && w_misalign) r_fault <= 1'b1;
    end
  end

  // Request decodes straight from the state register, so reset drops it at once
  assign imem_req      = (r_state == S_REQ);
  assign imem_addr     = r_pc;
  assign instr_valid   = r_valid;
  assign instr         = r_instr;
  assign opcode        = r_instr[6:0];
  assign pc_out        = r_pc_out;
  assign fault         = r_fault;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, wait states, stall, branch,
// misaligned-redirect fault, PC wrap and reset during an outstanding request.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        fault;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    #2;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 || retired_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b valid=%b fault=%b retired=%0d, want 0/0/0/0",
               imem_req, instr_valid, fault, retired_count);
    end
    n_checks++;
    if (instr !== 32'h0000_0013 || opcode !== 7'b0010011 || pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h opcode=%b pc_out=%h, want 00000013/0010011/0", instr, opcode, pc_out);
    end
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL dead_cycle: req=%b want 0", imem_req);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = 32'h0020_8033;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0020_8033 || opcode !== 7'b0110011 ||
        pc_out !== 32'd0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_wait: valid=%b instr=%h opcode=%b pc_out=%h req=%b, want 1/00208033/0110011/0/0",
               instr_valid, instr, opcode, pc_out, imem_req);
    end
  endtask

  task automatic test_wait_states();
    tick();  // release instr @0 sequentially
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4 || retired_count !== 32'd1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_advance: req=%b addr=%h retired=%0d valid=%b, want 1/4/1/0",
               imem_req, imem_addr, retired_count, instr_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd4 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b, want 1/4/0", i, imem_req, imem_addr, instr_valid);
      end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0093 || pc_out !== 32'd4) begin
      n_fail++;
      $display("FAIL wait_capture: valid=%b instr=%h pc_out=%h, want 1/00000093/4", instr_valid, instr, pc_out);
    end
    tick(); tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL no_extra_req: req=%b want 0", imem_req);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0000_0093 || pc_out !== 32'd4 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: valid=%b instr=%h pc_out=%h req=%b, want 1/00000093/4/0",
                 i, instr_valid, instr, pc_out, imem_req);
      end
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    n_checks++;
    if (imem_addr !== 32'd8 || imem_req !== 1'b1 || retired_count !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_release: addr=%h req=%b retired=%0d, want 8/1/2", imem_addr, imem_req, retired_count);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0113;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h100 || imem_req !== 1'b1 || retired_count !== 32'd3 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_addr: addr=%h req=%b retired=%0d valid=%b, want 100/1/3/0",
               imem_addr, imem_req, retired_count, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0263;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'h100 || instr_valid !== 1'b1 || opcode !== 7'b1100011) begin
      n_fail++;
      $display("FAIL branch_pc_out: pc_out=%h valid=%b opcode=%b, want 100/1/1100011", pc_out, instr_valid, opcode);
    end
  endtask

  task automatic test_fault();
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || retired_count !== 32'd4 ||
        imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fault_set: fault=%b valid=%b req=%b retired=%0d addr=%h, want 1/0/0/4/100",
               fault, instr_valid, imem_req, retired_count, imem_addr);
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || fault !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_hold%0d: req=%b fault=%b valid=%b, want 0/1/0", i, imem_req, fault, instr_valid);
      end
    end
    imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (fault !== 1'b0 || retired_count !== 32'd0 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b retired=%0d addr=%h, want 0/0/0", fault, retired_count, imem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL refetch: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_redirect: addr=%h req=%b want fffffffc/1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pc_out: pc_out=%h valid=%b want fffffffc/1", pc_out, instr_valid);
    end
    tick();
    n_checks++;
    if (imem_addr !== 32'd0 || imem_req !== 1'b1 || retired_count !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_seq: addr=%h req=%b retired=%0d, want 0/1/2", imem_addr, imem_req, retired_count);
    end
  endtask

  task automatic test_reset_mid();
    tick();  // one wait cycle, request outstanding at addr 0
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_req: req=%b valid=%b want 0/0", imem_req, instr_valid);
    end
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_ack: valid=%b instr=%h req=%b, want 0/00000013/1", instr_valid, instr, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
